// File: rtl/aes_key_schedule_if.sv
// Request/response bundle between the AES round FSM and the key schedule.
// The master drives init/key/round; the key schedule answers with round_key/ready.
interface aes_key_schedule_if;
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;

  modport master (
    output init, keylen, key, round,
    input  round_key, ready
  );

  modport slave (
    input  init, keylen, key, round,
    output round_key, ready
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES round-key expander and store: one round key per cycle through a single 32-bit S-box.
// Optional macro AES_KEY256_EN adds AES-256 support (15 entries); default build is AES-128 only.
module aes_sbox (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]], SBOX[i_word[15:8]], SBOX[i_word[7:0]]};
endmodule

module aes_key_schedule (
  input  logic              clk,
  input  logic              reset_n,
  aes_key_schedule_if.slave bus
);
`ifdef AES_KEY256_EN
  localparam int NUM_KEYS = 15;
`else
  localparam int NUM_KEYS = 11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_GEN, S_DONE} state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [127:0] r_store [NUM_KEYS];
  logic [127:0] r_keyHi;
  logic [127:0] r_prev1;
  logic [3:0]   r_cnt;
  logic [7:0]   r_rcon;
`ifdef AES_KEY256_EN
  logic [127:0] r_keyLo;
  logic [127:0] r_prev2;
  logic         r_keylen;
`else
  logic         w_unusedInputs;
  assign w_unusedInputs = ^{bus.keylen, bus.key[127:0]};
`endif

  logic         w_isLast;
  logic         w_rconStep;
  logic [3:0]   w_maxIdx;
  logic [127:0] w_chainBase;
  logic [31:0]  w_sboxIn;
  logic [31:0]  w_sboxOut;
  logic [31:0]  w_rconWord;
  logic [31:0]  w_temp;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  aes_sbox u_sbox (
    .i_word(w_sboxIn),
    .o_word(w_sboxOut)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (bus.init) w_nextState = S_INIT;
      S_INIT:  w_nextState = S_GEN;
      S_GEN:   if (w_isLast) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign bus.ready = (r_state == S_IDLE);

  // AES-256 odd rounds skip rotate and rcon and chain against key r-2 instead of r-1.
  always_comb begin
    w_isLast    = (r_cnt == 4'd10);
    w_maxIdx    = 4'd10;
    w_rconStep  = 1'b1;
    w_chainBase = r_prev1;
    w_sboxIn    = {r_prev1[23:0], r_prev1[31:24]};
    w_rconWord  = {r_rcon, 24'h000000};
`ifdef AES_KEY256_EN
    if (r_keylen) begin
      w_isLast    = (r_cnt == 4'd14);
      w_maxIdx    = 4'd14;
      w_rconStep  = ~r_cnt[0];
      w_chainBase = r_prev2;
      if (r_cnt[0]) begin
        w_sboxIn   = r_prev1[31:0];
        w_rconWord = 32'h0;
      end
    end
`endif
  end

  assign w_temp = w_sboxOut ^ w_rconWord;
  assign w_w0   = w_chainBase[127:96] ^ w_temp;
  assign w_w1   = w_chainBase[95:64]  ^ w_w0;
  assign w_w2   = w_chainBase[63:32]  ^ w_w1;
  assign w_w3   = w_chainBase[31:0]   ^ w_w2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) r_store[i] <= '0;
      r_keyHi <= '0;
      r_prev1 <= '0;
      r_cnt   <= '0;
      r_rcon  <= '0;
`ifdef AES_KEY256_EN
      r_keyLo  <= '0;
      r_prev2  <= '0;
      r_keylen <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.init) begin
            r_keyHi <= bus.key[255:128];
`ifdef AES_KEY256_EN
            r_keyLo  <= bus.key[127:0];
            r_keylen <= bus.keylen;
`endif
          end
        end
        S_INIT: begin
          r_store[0] <= r_keyHi;
          r_prev1    <= r_keyHi;
          r_cnt      <= 4'd1;
          r_rcon     <= 8'h01;
`ifdef AES_KEY256_EN
          if (r_keylen) begin
            r_store[1] <= r_keyLo;
            r_prev2    <= r_keyHi;
            r_prev1    <= r_keyLo;
            r_cnt      <= 4'd2;
          end
`endif
        end
        S_GEN: begin
          for (int i = 1; i < NUM_KEYS; i++) begin
            if (r_cnt == 4'(i)) r_store[i] <= {w_w0, w_w1, w_w2, w_w3};
          end
          r_prev1 <= {w_w0, w_w1, w_w2, w_w3};
`ifdef AES_KEY256_EN
          r_prev2 <= r_prev1;
`endif
          if (w_rconStep) r_rcon <= xtime(r_rcon);
          r_cnt <= r_cnt + 4'd1;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Indices beyond the captured key length read as zero, hiding stale AES-256 entries.
  always_comb begin
    bus.round_key = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bus.round == 4'(i) && bus.round <= w_maxIdx) bus.round_key = r_store[i];
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed self-checking bench for aes_key_schedule using FIPS-197 key-expansion vectors.
// Builds with or without AES_KEY256_EN; the keylen=1 checks adapt to the build.
module tb_aes_key_schedule;
  logic clk = 1'b0;
  logic reset_n;
  int   vecCount  = 0;
  int   missCount = 0;

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK9    = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEYB   = 128'hffeeddccbbaa99887766554433221100;

  aes_key_schedule_if bus ();

  aes_key_schedule dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkReady(input string tag, input logic exp);
    checkOutput(tag, {127'b0, bus.ready}, {127'b0, exp});
  endtask

  task automatic readCheck(input string tag, input logic [3:0] r, input logic [127:0] exp);
    @(negedge clk);
    bus.round = r;
    #1;
    checkOutput($sformatf("%s round %0d", tag, r), bus.round_key, exp);
  endtask

  // Single-cycle init pulse; returns in cycle t+1.
  task automatic applyStimulus(input logic [255:0] k, input logic kl);
    bus.key    = k;
    bus.keylen = kl;
    bus.init   = 1'b1;
    tick();
    bus.init   = 1'b0;
  endtask

  // Called in cycle t+1; checks ready low through t+lowCycles and high at t+lowCycles+1.
  task automatic checkLatency(input string tag, input int lowCycles);
    for (int n = 1; n <= lowCycles; n++) begin
      if (n > 1) tick();
      checkReady($sformatf("%s ready t+%0d", tag, n), 1'b0);
    end
    tick();
    checkReady($sformatf("%s ready t+%0d", tag, lowCycles + 1), 1'b1);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.init   = 1'b0;
    bus.keylen = 1'b0;
    bus.key    = '0;
    bus.round  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] reset state");
    checkReady("reset ready", 1'b1);
    for (int r = 0; r < 16; r++) readCheck("reset", 4'(r), 128'h0);

    $display("[TB] AES-128 expansion");
    applyStimulus({KEY128, 128'h0}, 1'b0);
    checkLatency("aes128", 12);
    readCheck("aes128", 4'd0, KEY128);
    readCheck("aes128", 4'd1, RK1);
    readCheck("aes128", 4'd2, RK2);
    readCheck("aes128", 4'd9, RK9);
    readCheck("aes128", 4'd10, RK10);
    readCheck("aes128", 4'd11, 128'h0);
    readCheck("aes128", 4'd15, 128'h0);

    $display("[TB] init during expansion");
    applyStimulus({KEY128, 128'h0}, 1'b0);
    for (int n = 2; n <= 5; n++) tick();
    bus.key  = {KEYB, KEYB};
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    for (int n = 7; n <= 12; n++) tick();
    checkReady("midinit ready t+12", 1'b0);
    tick();
    checkReady("midinit ready t+13", 1'b1);
    readCheck("midinit", 4'd0, KEY128);
    readCheck("midinit", 4'd10, RK10);

    $display("[TB] init held high");
    bus.key  = {KEY128, 128'h0};
    bus.init = 1'b1;
    tick();
    checkReady("held ready t+1", 1'b0);
    for (int n = 2; n <= 13; n++) tick();
    checkReady("held ready t+13", 1'b1);
    tick();
    checkReady("held restart t+14", 1'b0);
    bus.init = 1'b0;
    for (int n = 15; n <= 25; n++) tick();
    checkReady("held ready t+25", 1'b0);
    tick();
    checkReady("held ready t+26", 1'b1);
    readCheck("held", 4'd1, RK1);
    readCheck("held", 4'd10, RK10);

    $display("[TB] reset mid-expansion");
    applyStimulus({KEYB, KEYB}, 1'b0);
    for (int n = 2; n <= 6; n++) tick();
    reset_n = 1'b0;
    tick();
    checkReady("abort ready", 1'b1);
    for (int r = 0; r < 16; r++) readCheck("abort", 4'(r), 128'h0);
    reset_n = 1'b1;
    tick();
    applyStimulus({KEY128, 128'h0}, 1'b0);
    checkLatency("after abort", 12);
    readCheck("after abort", 4'd1, RK1);
    readCheck("after abort", 4'd10, RK10);

`ifdef AES_KEY256_EN
    $display("[TB] AES-256 expansion");
    applyStimulus(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1);
    checkLatency("aes256", 15);
    readCheck("aes256", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
    readCheck("aes256", 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
    readCheck("aes256", 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
    readCheck("aes256", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    readCheck("aes256", 4'd15, 128'h0);
    applyStimulus({KEY128, 128'h0}, 1'b0);
    checkLatency("aes128 after 256", 12);
    readCheck("aes128 after 256", 4'd10, RK10);
    readCheck("aes128 after 256", 4'd14, 128'h0);
`else
    $display("[TB] keylen ignored");
    applyStimulus({KEY128, 128'hdeadbeefcafef00d0123456789abcdef}, 1'b1);
    checkLatency("keylen1", 12);
    readCheck("keylen1", 4'd0, KEY128);
    readCheck("keylen1", 4'd1, RK1);
    readCheck("keylen1", 4'd10, RK10);
    readCheck("keylen1", 4'd14, 128'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
